// File: rtl/aes_enc_pkg.sv
// -----------------------------------------------------------------------------
// aes_enc_pkg
// Shared constants and types for the AES-256 encryption round controller.
//   NR       : number of AES rounds (14 for AES-256)
//   NKEYS    : number of round keys held in the key ROM (NR+1)
//   KADDR_W  : key-ROM address width (2**KADDR_W >= NKEYS)
//   LOAD_CYC : cycles spent on the initial key addition (read + capture)
//   STAGE_W  : width of the per-window stage counter (ROUND_LAT up to 7)
// -----------------------------------------------------------------------------
package aes_enc_pkg;

    localparam int NR       = 14;
    localparam int NKEYS    = NR + 1;
    localparam int KADDR_W  = 4;
    localparam int LOAD_CYC = 2;
    localparam int STAGE_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        HOLD
    } enc_ctrl_state_t;

endpackage

// File: rtl/mod_enc_stage_timer.sv
// -----------------------------------------------------------------------------
// mod_enc_stage_timer
// Stage counter for one round window. Counts 0..ROUND_LAT-1 while en is high
// and wraps at the window end; clr forces the next count to 0.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : restart the count at 0 on the next edge (priority over en)
//   en          : advance the count
//   stage_cnt   : current stage (registered)
//   stage_nxt   : stage the counter will hold after the next edge
//   last_stage  : current stage is ROUND_LAT-1 (window ends this cycle)
//   rd_stage    : next stage is ROUND_LAT-2 (key-ROM read cycle is next)
//   rk_stage    : next stage is ROUND_LAT-1 (key capture cycle is next)
// The rd/rk pulses look one cycle ahead so that the controller can register
// its strobes and still have them land in the right stage.
// -----------------------------------------------------------------------------
module mod_enc_stage_timer
    import aes_enc_pkg::*;
#(
    parameter int ROUND_LAT = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr,
    input  logic               en,
    output logic [STAGE_W-1:0] stage_cnt,
    output logic [STAGE_W-1:0] stage_nxt,
    output logic               last_stage,
    output logic               rd_stage,
    output logic               rk_stage
);

    assign last_stage = (stage_cnt == STAGE_W'(ROUND_LAT - 1));

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        stage_nxt = stage_cnt;
        if (clr) begin
            stage_nxt = '0;
        end else if (en) begin
            stage_nxt = last_stage ? '0 : stage_cnt + 1'b1;
        end
    end

    assign rd_stage = (stage_nxt == STAGE_W'(ROUND_LAT - 2));
    assign rk_stage = (stage_nxt == STAGE_W'(ROUND_LAT - 1));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_cnt <= '0;
        end else begin
            stage_cnt <= stage_nxt;
        end
    end

endmodule

// File: rtl/mod_enc_round_ctrl.sv
// -----------------------------------------------------------------------------
// mod_enc_round_ctrl
// Round sequencer for the AES-256 encryption datapath. Accepts one block per
// handshake, runs the initial key addition (LOAD), rounds 1..NR-1 (ROUND) and
// the final round (FINAL, MixColumns bypassed), then holds out_valid (HOLD)
// until the consumer takes the ciphertext. One block in flight at a time.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   abort        : (only with AES_ENC_CTRL_ABORT_EN) synchronous abort to IDLE
//   in_valid     : input block available
//   in_ready     : controller can accept a block (IDLE only)
//   key_addr     : round-key index to the key ROM (0..NR)
//   key_rd_en    : key-ROM read enable (ROM read latency is one cycle)
//   sel_init     : 1 = addRoundKey takes the plaintext, 0 = round feedback
//   rk_en        : addRoundKey capture strobe, one per key addition
//   bypass_mix   : skip MixColumns (final round window)
//   round        : current round number (0 = initial key addition)
//   out_valid    : ciphertext valid at the addRoundKey output
//   out_ready    : consumer accepts the ciphertext
//   busy         : block in flight (any state other than IDLE)
// Optional build macro: AES_ENC_CTRL_ABORT_EN adds the abort input.
// All outputs are registered: they are computed from the next state.
// -----------------------------------------------------------------------------
module mod_enc_round_ctrl #(
    parameter int NR        = aes_enc_pkg::NR,
    parameter int ROUND_LAT = 3,
    parameter int KADDR_W   = aes_enc_pkg::KADDR_W
) (
    input  logic               clk,
    input  logic               resetn,
`ifdef AES_ENC_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    output logic [KADDR_W-1:0] key_addr,
    output logic               key_rd_en,
    output logic               sel_init,
    output logic               rk_en,
    output logic               bypass_mix,
    output logic [KADDR_W-1:0] round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    import aes_enc_pkg::*;

    localparam logic [KADDR_W-1:0] LAST_ROUND = KADDR_W'(NR);
    localparam logic [KADDR_W-1:0] FIRST_RND  = KADDR_W'(1);

    enc_ctrl_state_t    state, state_nxt;
    logic [KADDR_W-1:0] round_nxt;
    logic               abort_w;
    logic               in_window_nxt;
    logic               timer_clr, timer_en;
    logic [STAGE_W-1:0] stage_cnt, stage_nxt;
    logic               last_stage, rd_stage, rk_stage;

`ifdef AES_ENC_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    mod_enc_stage_timer #(
        .ROUND_LAT (ROUND_LAT)
    ) u_stage_timer (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (timer_clr),
        .en         (timer_en),
        .stage_cnt  (stage_cnt),
        .stage_nxt  (stage_nxt),
        .last_stage (last_stage),
        .rd_stage   (rd_stage),
        .rk_stage   (rk_stage)
    );

    always_comb begin
        state_nxt = state;
        round_nxt = round;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (stage_cnt == STAGE_W'(LOAD_CYC - 1)) begin
                    round_nxt = FIRST_RND;
                    state_nxt = (LAST_ROUND == FIRST_RND) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                if (last_stage) begin
                    round_nxt = round + 1'b1;
                    if (round_nxt == LAST_ROUND) begin
                        state_nxt = FINAL;
                    end
                end
            end
            FINAL: begin
                if (last_stage) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    round_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                round_nxt = '0;
            end
        endcase
        // Abort wins over everything, including the output handshake.
        if (abort_w) begin
            state_nxt = IDLE;
            round_nxt = '0;
        end
    end

    assign in_window_nxt = (state_nxt == ROUND) || (state_nxt == FINAL);
    // Every state change restarts the stage count; inside ROUND the timer
    // wraps on its own at each window end.
    assign timer_clr     = (state_nxt != state);
    assign timer_en      = (state == LOAD) || (state == ROUND) || (state == FINAL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            round      <= '0;
            key_addr   <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            key_rd_en  <= 1'b0;
            sel_init   <= 1'b0;
            rk_en      <= 1'b0;
            bypass_mix <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            round      <= round_nxt;
            // The key index tracks the round: 0 in LOAD, NR through FINAL/HOLD.
            key_addr   <= round_nxt;
            in_ready   <= (state_nxt == IDLE) && !abort_w;
            busy       <= (state_nxt != IDLE);
            key_rd_en  <= ((state_nxt == LOAD) && (stage_nxt == '0))
                          || (in_window_nxt && rd_stage);
            sel_init   <= (state_nxt == LOAD);
            rk_en      <= ((state_nxt == LOAD) && (stage_nxt == STAGE_W'(LOAD_CYC - 1)))
                          || (in_window_nxt && rk_stage);
            bypass_mix <= (state_nxt == FINAL);
            out_valid  <= (state_nxt == HOLD);
        end
    end

endmodule

// File: tb/tb_mod_enc_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod_enc_round_ctrl
// Self-checking bench for mod_enc_round_ctrl. A reference model describes each
// block as "k cycles since the accept edge" and derives the expected outputs
// arithmetically from k (LOAD, round window, stage within window, HOLD).
// Build with AES_ENC_CTRL_ABORT_EN to exercise the abort input as well.
// -----------------------------------------------------------------------------
module tb_mod_enc_round_ctrl;

    localparam int NR     = 14;
    localparam int RL     = 3;
    localparam int KW     = 4;
    localparam int LAST_K = 2 + NR * RL;   // edges from accept to first out_valid
    localparam int HOLD_K = LAST_K + 1;    // k value while holding the result
    localparam int M_RST  = 0;
    localparam int M_IDLE = 1;
    localparam int M_BUSY = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          ab = 1'b0;
    logic          in_ready, key_rd_en, sel_init, rk_en, bypass_mix, out_valid, busy;
    logic [KW-1:0] key_addr, round;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int mode, k, acc_edge, prev_acc;
    int obs_rk, obs_sel, obs_byp;
    bit seen_ov, blk_done, b2b;

    always #5 clk = ~clk;

    mod_enc_round_ctrl #(
        .NR        (NR),
        .ROUND_LAT (RL),
        .KADDR_W   (KW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
`ifdef AES_ENC_CTRL_ABORT_EN
        .abort      (ab),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key_addr   (key_addr),
        .key_rd_en  (key_rd_en),
        .sel_init   (sel_init),
        .rk_en      (rk_en),
        .bypass_mix (bypass_mix),
        .round      (round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc_n);
    endtask

    // {in_ready, busy, key_addr, key_rd_en, sel_init, rk_en, bypass_mix, round, out_valid}
    function automatic logic [14:0] obs_vec();
        return {in_ready, busy, key_addr, key_rd_en, sel_init, rk_en, bypass_mix, round, out_valid};
    endfunction

    function automatic logic [14:0] exp_vec(input int m, input int kk);
        logic ir = 1'b0, bz = 1'b0, rd = 1'b0, sel = 1'b0, rk = 1'b0, byp = 1'b0, ov = 1'b0;
        int   ka = 0, rnd = 0, w, s;
        if (m == M_IDLE) begin
            ir = 1'b1;
        end else if (m == M_BUSY) begin
            bz = 1'b1;
            if (kk == 1) begin
                rd = 1'b1; sel = 1'b1;
            end else if (kk == 2) begin
                sel = 1'b1; rk = 1'b1;
            end else if (kk <= LAST_K) begin
                w   = (kk - 3) / RL;
                s   = (kk - 3) % RL;
                rnd = w + 1;
                ka  = rnd;
                rd  = (s == RL - 2);
                rk  = (s == RL - 1);
                byp = (rnd == NR);
            end else begin
                ka = NR; rnd = NR; ov = 1'b1;
            end
        end
        return {ir, bz, ka[KW-1:0], rd, sel, rk, byp, rnd[KW-1:0], ov};
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare at negedge.
    task automatic cyc(input logic iv, input logic ordy);
        in_valid  = iv;
        out_ready = ordy;
        @(posedge clk);
        cyc_n++;
        blk_done = 1'b0;
        case (mode)
            M_RST:  if (!ab) mode = M_IDLE;
            M_IDLE: begin
                if (ab) begin
                    mode = M_RST;
                end else if (iv) begin
                    mode = M_BUSY;
                    k    = 1;
                    if (b2b && prev_acc >= 0) check("accept_gap", cyc_n - prev_acc, HOLD_K + 1);
                    prev_acc = cyc_n;
                    acc_edge = cyc_n;
                    obs_rk = 0; obs_sel = 0; obs_byp = 0; seen_ov = 1'b0;
                end
            end
            default: begin
                if (ab) mode = M_RST;
                else if (k < HOLD_K) k++;
                else if (ordy) begin
                    mode = M_IDLE;
                    blk_done = 1'b1;
                end
            end
        endcase
        @(negedge clk);
        check("outputs", obs_vec(), exp_vec(mode, k));
        if (mode == M_BUSY) begin
            if (rk_en) begin
                check("rk_addr", key_addr, obs_rk);
                obs_rk++;
            end
            if (sel_init) obs_sel++;
            if (bypass_mix) obs_byp++;
            if (out_valid && !seen_ov) begin
                seen_ov = 1'b1;
                check("latency", cyc_n - acc_edge, LAST_K);
            end
        end
        if (blk_done) begin
            check("rk_count", obs_rk, NR + 1);
            check("sel_count", obs_sel, 2);
            check("byp_count", obs_byp, RL);
        end
    endtask

    task automatic reset_mid();
        #2 resetn = 1'b0;
        #1 check("rst_async", obs_vec(), 15'd0);
        mode = M_RST;
        k    = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold", obs_vec(), 15'd0);
        resetn = 1'b1;
    endtask

    initial begin
        int n_ov;
        mode = M_RST; k = 0; prev_acc = -1; b2b = 1'b0; acc_edge = 0;
        obs_rk = 0; obs_sel = 0; obs_byp = 0; seen_ov = 1'b0; blk_done = 1'b0;

        // Reset state, then release away from the clock edge.
        #1 check("reset_vals", obs_vec(), 15'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cyc(1'b0, 1'b0);
        check("idle_ready", in_ready, 1'b1);

        // Single block, consumer always ready.
        cyc(1'b1, 1'b1);
        repeat (HOLD_K + 2) cyc(1'b0, 1'b1);

        // Backpressure: 10 extra cycles in HOLD.
        cyc(1'b1, 1'b0);
        repeat (HOLD_K - 1) cyc(1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_addr", key_addr, NR);
        cyc(1'b0, 1'b1);
        check("bp_ready", in_ready, 1'b1);

        // in_valid held high: back-to-back blocks.
        b2b = 1'b1; prev_acc = -1;
        repeat (3 * (HOLD_K + 1) + 2) cyc(1'b1, 1'b1);
        b2b = 1'b0;
        repeat (HOLD_K + 2) cyc(1'b0, 1'b1);

        // Reset in the middle of round 7, then a normal block.
        cyc(1'b1, 1'b1);
        repeat (3 + 6 * RL) cyc(1'b0, 1'b1);
        check("round7", round, 7);
        reset_mid();
        cyc(1'b0, 1'b1);
        check("rst_round", round, 0);
        cyc(1'b1, 1'b1);
        repeat (HOLD_K + 1) cyc(1'b0, 1'b1);

`ifdef AES_ENC_CTRL_ABORT_EN
        // Abort during round 5: no result may ever appear.
        cyc(1'b1, 1'b1);
        repeat (3 + 4 * RL) cyc(1'b0, 1'b1);
        check("round5", round, 5);
        ab = 1'b1;
        cyc(1'b0, 1'b1);
        ab = 1'b0;
        n_ov = 0;
        repeat (HOLD_K + 5) begin
            cyc(1'b0, 1'b1);
            if (out_valid) n_ov++;
        end
        check("abort_no_ov", n_ov, 0);

        // Abort together with out_ready in HOLD.
        cyc(1'b1, 1'b0);
        repeat (HOLD_K - 1) cyc(1'b0, 1'b0);
        ab = 1'b1;
        cyc(1'b0, 1'b1);
        check("abort_ov", out_valid, 1'b0);
        cyc(1'b1, 1'b1);
        check("abort_ir", in_ready, 1'b0);
        ab = 1'b0;
        cyc(1'b1, 1'b0);
        check("abort_rel", in_ready, 1'b1);
        cyc(1'b0, 1'b1);
        repeat (HOLD_K + 2) cyc(1'b0, 1'b1);
`endif

        // Randomized traffic and backpressure.
        repeat (400) begin
`ifdef AES_ENC_CTRL_ABORT_EN
            ab = ($urandom_range(0, 63) == 0);
`endif
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
        ab = 1'b0;
        repeat (HOLD_K + 2) cyc(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_enc_round_ctrl.md
Name: mod_enc_round_ctrl

Overview:
Round sequencer for the AES-256 encryption datapath. It accepts one 128-bit block per handshake and drives the key-ROM address, the plaintext/feedback mux select, the addRoundKey capture strobe and the final-round MixColumns bypass. It walks the initial key addition, rounds 1..NR-1 and the final round, then holds a result-valid handshake. One block is in flight at a time; there is no overlap between blocks.

Parameters:
NR, 14, number of AES rounds (AES-256).
ROUND_LAT, 3, cycles per round window (SubBytes, ShiftRows/MixColumns and addRoundKey register stages); legal range 2..7.
KADDR_W, 4, key-ROM address width; must satisfy 2**KADDR_W >= NR+1.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
in_valid  in  1  input block available
in_ready  out  1  controller can accept a block
key_addr  out  KADDR_W  round-key index to the key ROM (0..NR)
key_rd_en  out  1  key-ROM read enable
sel_init  out  1  1 = addRoundKey input is the plaintext; 0 = round feedback
rk_en  out  1  addRoundKey capture strobe, one cycle per key addition
bypass_mix  out  1  1 = skip MixColumns (final round)
round  out  KADDR_W  current round number (0 = initial key addition)
out_valid  out  1  ciphertext valid at addRoundKey output
out_ready  in  1  consumer accepts the ciphertext
busy  out  1  block in flight (any state other than IDLE)

Behaviour:
- Reset values: in_ready=0 while resetn=0, then 1 in IDLE. All other outputs 0; key_addr=0; round=0; state=IDLE; stage_cnt=0.
- FSM states: IDLE, LOAD, ROUND, FINAL, HOLD. All outputs are registered.
- IDLE: in_ready=1. When in_valid&&in_ready, go to LOAD.
- LOAD (2 cycles):
  - Cycle 0: key_addr=0, key_rd_en=1, sel_init=1.
  - Cycle 1: sel_init=1, rk_en=1. Key ROM read latency is 1 cycle.
  - Then go to ROUND with round=1.
- ROUND:
  - Each round window lasts ROUND_LAT cycles. stage_cnt counts 0..ROUND_LAT-1.
  - key_addr=round is held for the whole window. key_rd_en=1 at stage_cnt==ROUND_LAT-2.
  - rk_en=1 at stage_cnt==ROUND_LAT-1, and sel_init=0.
  - At the end of the window round increments. When the next round equals NR, go to FINAL.
- FINAL: same timing as a ROUND window with round=NR, plus bypass_mix=1 for the whole window. At the end of the window go to HOLD.
- HOLD: out_valid=1 and held until out_ready=1. On the handshake cycle, next state is IDLE: out_valid=0, round=0, in_ready=1.
- Latency: from the accept cycle to the first out_valid cycle is 2+NR*ROUND_LAT cycles (44 with defaults).
- Boundary rules:
  - in_valid while busy is ignored (in_ready=0).
  - out_ready while not in HOLD has no effect.
  - stage_cnt wraps to 0 at every window end. round never exceeds NR.
  - A new block is never accepted in the same cycle as the output handshake; the minimum gap between accepts is latency+1 cycles.
  - resetn low mid-operation returns immediately to IDLE with reset values. No partial out_valid is produced.

Optional Feature:
Macro AES_ENC_CTRL_ABORT_EN.
- With it: adds input port abort (1 bit, synchronous).
  - abort=1 in any state forces IDLE on the next edge with round=0, and outputs go to their reset values except in_ready.
  - It has priority over the out handshake: the result is discarded.
  - While abort=1, in_ready=0, so no block is accepted.
- Without it: no abort port; a block always runs to HOLD.

Decomposition:
- Shared package aes_enc_pkg holds:
  - NR and NKEYS (=NR+1).
  - KADDR_W.
  - typedef enum logic [2:0] enc_ctrl_state_t {IDLE, LOAD, ROUND, FINAL, HOLD}.
  - The LOAD_CYC=2 constant.
- One natural sub-module: mod_enc_stage_timer, the stage_cnt counter. Ports: clk, resetn, clr, en. It produces the last_stage and rd_stage pulses.

Test Plan:
1. Reset, then a single block: in_valid=1 at cycle 0 → in_ready drops next cycle; rk_en pulses exactly 15 times; the key_addr sequence at the rk_en pulses is 0,1,...,14; out_valid rises 44 cycles after the accept cycle.
2. bypass_mix check → bypass_mix=1 only during the 3 cycles of round 14 and 0 in rounds 1..13; sel_init=1 only in the 2 LOAD cycles.
3. Backpressure: out_ready=0 for 10 cycles in HOLD → out_valid stays 1 and key_addr stays 14; out_ready=1 → next cycle IDLE with in_ready=1.
4. in_valid held high continuously for 3 blocks with out_ready=1 → accepts are 46 cycles apart (45 cycles: accept to handshake, plus 1); no accept while busy=1.
5. resetn pulsed low during round 7 → all outputs 0 asynchronously; after release in_ready=1 and round=0; a new block completes with the normal 44-cycle latency.
6. (AES_ENC_CTRL_ABORT_EN) abort=1 at round 5 → IDLE next edge, out_valid never asserts; abort=1 in HOLD together with out_ready=1 → out_valid drops and in_ready stays 0 until abort=0.
